spongent_msg_ctrl: RTL and testbench
====================================

SPONGENT_MSG_CTRL -- requirements
Module: spongent_msg_ctrl

Interface
REQ-001 Parameter RATE_BYTES, default 2: sponge rate in bytes; block width R = 8*RATE_BYTES.
REQ-002 Parameter OUT_BLOCKS, default 8: number of R-bit digest blocks squeezed.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_data  in  8  message byte.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-008 flush  in  1  end-of-message pulse; empty messages allowed.
REQ-009 sp_start_continue  out  1  one-cycle start pulse to the sponge FSM.
REQ-010 sp_msg_data_available  out  1  1 = absorb, 0 = squeeze; qualified by sp_start_continue.
REQ-011 sp_msg_data  out  R  padded block to absorb, first byte in bits [R-1:R-8].
REQ-012 sp_busy  in  1  sponge FSM busy.
REQ-013 sp_state_rate  in  R  rate part of sponge state.
REQ-014 out_data  out  R  digest block.
REQ-015 out_valid / out_ready  out / in  1 each  digest valid/ready handshake.
REQ-016 done  out  1  high after final digest block is accepted.
REQ-017 msg_len  out  16  accepted byte count (see Configuration).

Function
REQ-018 States: WARM, FILL, ABS_REQ, ABS_WAIT, OUT, SQ_REQ, SQ_WAIT, DONE.
REQ-019 WARM lasts exactly one cycle after reset release, then FILL; in_ready=0 in WARM.
REQ-020 FILL: in_ready=1 while buffered count < RATE_BYTES; each accepted byte is stored at the next byte position.
REQ-021 FILL, buffer reaches RATE_BYTES bytes without flush: go to ABS_REQ with a non-final full block.
REQ-022 Flush in FILL with k < RATE_BYTES buffered bytes: byte k = 0x80, remaining bytes 0x00; block is final.
REQ-023 Flush with k = RATE_BYTES buffered bytes: absorb the full block non-final, then absorb a final pad block 0x80 followed by zeros.
REQ-024 in_valid and flush in the same cycle: the byte is accepted first and padding applies after it.
REQ-025 Flush outside FILL is ignored; in_ready=0 outside FILL.
REQ-026 ABS_REQ lasts one cycle:
- sp_start_continue=1, sp_msg_data_available=1, sp_msg_data = block.
- Next state ABS_WAIT.
REQ-027 sp_msg_data holds the block from ABS_REQ until ABS_WAIT exits.
REQ-028 sp_busy is not sampled in the REQ cycle.
REQ-029 ABS_WAIT exit when sp_busy=0:
- pending pad block -> ABS_REQ;
- final block absorbed -> OUT with block index 0;
- otherwise -> FILL with buffer cleared.
REQ-030 OUT: out_valid=1, out_data = sp_state_rate; both held stable until out_ready.
REQ-031 OUT with out_ready: index = OUT_BLOCKS-1 goes to DONE; otherwise increment index and go to SQ_REQ.
REQ-032 SQ_REQ lasts one cycle:
- sp_start_continue=1, sp_msg_data_available=0.
- Next state SQ_WAIT, which goes to OUT when sp_busy=0.
REQ-033 DONE: done=1, all other handshake outputs 0; terminal until reset.
REQ-034 sp_start_continue is never asserted in two consecutive cycles.

Reset
REQ-035 Reset asserted, including mid-operation: state WARM, buffer, index and msg_len 0.
REQ-036 During reset all outputs are 0 immediately.

Configuration
REQ-037 Macro SPONGENT_MSG_COUNT_EN defined:
- msg_len increments on every accepted byte.
- msg_len saturates at 0xFFFF.
REQ-038 Macro SPONGENT_MSG_COUNT_EN undefined: msg_len tied to 0 and no counter logic exists.

Verification
REQ-039 Reset release, flush in first FILL cycle:
- one absorb pulse with sp_msg_data=0x8000;
- then 8 out blocks and 7 squeeze pulses;
- done=1.
REQ-040 Bytes 0xAB, 0xCD then flush -> absorb 0xABCD, busy cycle, then absorb 0x8000, then OUT.
REQ-041 Byte 0x12 with flush in the same cycle -> single absorb pulse with sp_msg_data=0x1280.
REQ-042 out_ready=0 for 5 cycles in OUT -> out_valid=1, out_data unchanged and no sp_start_continue; pulse follows out_ready.
REQ-043 Reset asserted during ABS_WAIT:
- all outputs 0 in the same cycle;
- after release, in_ready=0 for one cycle, then 1.
REQ-044 SPONGENT_MSG_COUNT_EN defined, 5 bytes then flush -> msg_len=5; undefined -> msg_len=0.

Source files
------------

// File: rtl/spongent_msg_ctrl.sv
// spongent_msg_ctrl: pads message bytes into rate blocks and drives the sponge absorb/squeeze handshake (optional byte counter: SPONGENT_MSG_COUNT_EN)
module spongent_msg_ctrl #(
    parameter int RATE_BYTES = 2,
    parameter int OUT_BLOCKS = 8,
    localparam int R = 8 * RATE_BYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic         sp_start_continue,
    output logic         sp_msg_data_available,
    output logic [R-1:0] sp_msg_data,
    input  logic         sp_busy,
    input  logic [R-1:0] sp_state_rate,
    output logic [R-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done,
    output logic [15:0]  msg_len
);
    localparam int CW = $clog2(RATE_BYTES + 1);
    localparam int IW = OUT_BLOCKS > 1 ? $clog2(OUT_BLOCKS) : 1;

    typedef enum logic [2:0] {WARM, FILL, ABS_REQ, ABS_WAIT, OUT, SQ_REQ, SQ_WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [R-1:0]  blk, blk_n;
    logic [CW-1:0] cnt, cnt_n, k_new;
    logic [IW-1:0] idx, idx_n;
    logic          fin, fin_n, pad, pad_n, accept, full;

    assign in_ready              = state == FILL && cnt < CW'(RATE_BYTES);
    assign accept                = in_valid & in_ready;
    assign k_new                 = cnt + CW'(accept);
    assign full                  = k_new == CW'(RATE_BYTES);
    assign sp_start_continue     = state == ABS_REQ || state == SQ_REQ;
    assign sp_msg_data_available = state == ABS_REQ;
    assign sp_msg_data           = (state == ABS_REQ || state == ABS_WAIT) ? blk : '0;
    assign out_valid             = state == OUT;
    assign out_data              = out_valid ? sp_state_rate : '0;
    assign done                  = state == DONE;

    // state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WARM;
            blk   <= '0;
            cnt   <= '0;
            idx   <= '0;
            fin   <= 1'b0;
            pad   <= 1'b0;
        end else begin
            state <= state_n;
            blk   <= blk_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            fin   <= fin_n;
            pad   <= pad_n;
        end
    end

    // next-state: byte packing, padding and absorb/squeeze sequencing
    always_comb begin
        state_n = state;
        blk_n   = blk;
        cnt_n   = cnt;
        idx_n   = idx;
        fin_n   = fin;
        pad_n   = pad;
        case (state)
            WARM: state_n = FILL;
            FILL: begin
                if (accept) begin
                    blk_n = blk | (R'(in_data) << (8 * (RATE_BYTES - 1 - int'(cnt))));
                    cnt_n = k_new;
                end
                if (flush) begin
                    if (!full)
                        blk_n = blk_n | (R'(8'h80) << (8 * (RATE_BYTES - 1 - int'(k_new))));
                    fin_n   = !full;
                    pad_n   = full;
                    state_n = ABS_REQ;
                end else if (full) begin
                    state_n = ABS_REQ;
                end
            end
            ABS_REQ: state_n = ABS_WAIT;
            ABS_WAIT: begin
                if (!sp_busy) begin
                    if (pad) begin
                        blk_n   = R'(8'h80) << (R - 8);
                        fin_n   = 1'b1;
                        pad_n   = 1'b0;
                        state_n = ABS_REQ;
                    end else if (fin) begin
                        idx_n   = '0;
                        state_n = OUT;
                    end else begin
                        blk_n   = '0;
                        cnt_n   = '0;
                        state_n = FILL;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (idx == IW'(OUT_BLOCKS - 1)) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + IW'(1);
                        state_n = SQ_REQ;
                    end
                end
            end
            SQ_REQ:  state_n = SQ_WAIT;
            SQ_WAIT: state_n = sp_busy ? SQ_WAIT : OUT;
            default: state_n = DONE;
        endcase
    end

`ifdef SPONGENT_MSG_COUNT_EN
    // count accepted bytes, sticking at all ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            msg_len <= '0;
        else if (accept && msg_len != 16'hFFFF)
            msg_len <= msg_len + 16'd1;
    end
`else
    assign msg_len = '0;
`endif
endmodule

// File: tb/tb_spongent_msg_ctrl.sv
// tb_spongent_msg_ctrl: directed scoreboard bench for spongent_msg_ctrl
module tb_spongent_msg_ctrl;
    localparam int R = 16;

    typedef struct {
        logic         avail;
        logic [R-1:0] data;
    } pulse_t;

    logic         clk, reset, in_valid, in_ready, flush;
    logic [7:0]   in_data;
    logic         sp_start_continue, sp_msg_data_available, sp_busy;
    logic [R-1:0] sp_msg_data, sp_state_rate, out_data;
    logic         out_valid, out_ready, done;
    logic [15:0]  msg_len;

    pulse_t exp_q[$];
    int     total = 0, bad = 0;
    int     out_cnt = 0, sq_cnt = 0, busy_len = 0, busy_left = 0;
    logic   prev_sc = 1'b0;
    logic [R-1:0] d0;
    logic [15:0]  exp_len;

    spongent_msg_ctrl #(.RATE_BYTES(2), .OUT_BLOCKS(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .sp_start_continue(sp_start_continue),
        .sp_msg_data_available(sp_msg_data_available), .sp_msg_data(sp_msg_data),
        .sp_busy(sp_busy), .sp_state_rate(sp_state_rate), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .done(done), .msg_len(msg_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sponge model: goes busy after each start pulse and produces a fresh rate value
    initial begin
        sp_busy = 1'b0;
        sp_state_rate = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                busy_left = 0;
            end else if (sp_start_continue) begin
                busy_left = busy_len;
                sp_state_rate = R'($urandom);
            end else if (busy_left > 0) begin
                busy_left--;
            end
            sp_busy = busy_left > 0;
        end
    end

    // monitor: pops expected start pulses and checks digest output
    always @(negedge clk) begin
        pulse_t p;
        if (sp_start_continue) begin
            chk("sc_back_to_back", prev_sc, 0);
            chk("sc_unexpected", exp_q.size() == 0, 0);
            if (exp_q.size() != 0) begin
                p = exp_q.pop_front();
                chk("sc_avail", sp_msg_data_available, p.avail);
                if (p.avail) chk("sc_block", sp_msg_data, p.data);
                else sq_cnt++;
            end
        end
        prev_sc = sp_start_continue;
        if (out_valid) begin
            chk("out_data", out_data, sp_state_rate);
            if (out_ready) out_cnt++;
        end
    end

    task automatic push_abs(input logic [R-1:0] d);
        exp_q.push_back('{1'b1, d});
    endtask

    task automatic push_sq();
        for (int i = 0; i < 7; i++) exp_q.push_back('{1'b0, '0});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outs", {in_ready, sp_start_continue, sp_msg_data_available, sp_msg_data,
                         out_valid, out_data, done, msg_len}, 0);
        exp_q.delete();
        out_cnt = 0;
        sq_cnt = 0;
        reset = 1'b0;
        #1;
        chk("warm_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("fill_ready", in_ready, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", n < 100, 1);
        in_data = b;
        in_valid = 1'b1;
        flush = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_to_done();
        int n = 0;
        out_ready = 1'b1;
        while (!done && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done", done, 1);
        chk("out_blocks", out_cnt, 8);
        chk("sq_pulses", sq_cnt, 7);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b1;

        // empty message flushed in first FILL cycle
        do_reset();
        push_abs(16'h8000);
        push_sq();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_to_done();
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("done_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", done, 1);

        // full block with flush: extra pad block, sponge busy in between
        do_reset();
        busy_len = 2;
        push_abs(16'hABCD);
        push_abs(16'h8000);
        push_sq();
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        run_to_done();

        // byte with flush in same cycle, then stalled output
        do_reset();
        busy_len = 1;
        out_ready = 1'b0;
        push_abs(16'h1280);
        push_sq();
        send(8'h12, 1'b1);
        for (int n = 0; n < 100 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("out_valid_seen", out_valid, 1);
        d0 = out_data;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, d0);
            chk("stall_no_sc", sp_start_continue, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("sq_after_ready", sp_start_continue, 1);
        chk("sq_avail", sp_msg_data_available, 0);
        run_to_done();

        // reset during ABS_WAIT
        do_reset();
        busy_len = 10;
        push_abs(16'h5566);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        chk("absreq_sc", sp_start_continue, 1);
        @(posedge clk);
        #1;
        chk("abswait_hold", sp_msg_data, 16'h5566);
        chk("abswait_sc", sp_start_continue, 0);
        reset = 1'b1;
        #1;
        chk("rst_async_outs", {in_ready, sp_start_continue, sp_msg_data_available, sp_msg_data,
                               out_valid, out_data, done, msg_len}, 0);
        do_reset();

        // five bytes then flush, byte counter
        busy_len = 1;
        push_abs(16'h0102);
        push_abs(16'h0304);
        push_abs(16'h0580);
        push_sq();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b1);
`ifdef SPONGENT_MSG_COUNT_EN
        exp_len = 16'd5;
`else
        exp_len = 16'd0;
`endif
        chk("msg_len", msg_len, exp_len);
        run_to_done();
        chk("msg_len_end", msg_len, exp_len);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
